gpio_padctrl: RTL and testbench
===============================

# gpio_padctrl

Parametrised GPIO pad controller sitting between the SoC register bus and the bidirectional pad ring, generalising fixed per-bit out/oe/in pad hookups to NUM_CH channels. Adds input synchronisation, per-channel programmable glitch filtering, atomic set/clear of outputs, and rising/falling-edge interrupts with sticky W1C status. Drives pad out_i/oe_i and receives pad in_o for every channel; irq_o goes to the SoC interrupt controller.

## Interface
- NUM_CH, 32, number of GPIO channels (1..32)
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- FILT_W, 4, glitch-filter counter width (1..8)
- clk  input  1  block clock
- rst  input  1  reset; synchronous, active-high
- reg_we  input  1  register write strobe
- reg_re  input  1  register read strobe
- reg_addr  input  4  word address
- reg_wdata  input  32  write data
- reg_rdata  output  32  read data, registered
- pad_in_i  input  NUM_CH  pad input (asynchronous)
- pad_out_o  output  NUM_CH  pad output value
- pad_oe_o  output  NUM_CH  pad output enable
- irq_o  output  1  OR of IRQ_STATUS

## Operation
- Register map (bits >= NUM_CH read 0, writes ignored):
  - 0 DATA_OUT RW; drives pad_out_o directly
  - 1 OUT_EN RW; drives pad_oe_o directly
  - 2 DATA_IN RO; filtered input value
  - 3 FILT_EN RW; per-channel filter enable
  - 4 FILT_TH RW; bits [FILT_W-1:0], shared threshold
  - 5 IRQ_RISE_EN RW
  - 6 IRQ_FALL_EN RW
  - 7 IRQ_STATUS RW1C; sticky
  - 8 OUT_SET WO; DATA_OUT |= wdata; reads 0
  - 9 OUT_CLR WO; DATA_OUT &= ~wdata; reads 0
  - 10..15 reserved: writes ignored, reads 0
- Sync: pad_in_i passes through SYNC_STAGES flops per channel -> s[i].
- Filter per channel, counter cnt[i] (FILT_W bits), filtered f[i]:
  - FILT_EN[i]=0: f[i] <= s[i] every cycle; cnt[i] <= 0.
  - FILT_EN[i]=1, s[i]==f[i]: cnt[i] <= 0.
  - FILT_EN[i]=1, s[i]!=f[i], cnt[i] >= FILT_TH: f[i] <= s[i], cnt[i] <= 0.
  - otherwise cnt[i] <= cnt[i]+1 (never wraps; capped by compare above).
  - Net: mismatch must persist FILT_TH+1 consecutive cycles; any bounce restarts count. Lowering FILT_TH mid-count takes effect immediately (>= compare).
- Edge detect: at the edge where f[i] goes 0->1 and IRQ_RISE_EN[i]=1, or 1->0 and IRQ_FALL_EN[i]=1, IRQ_STATUS[i] <= 1. Enable is sampled at that same edge; enabling later does not retro-set.
- IRQ_STATUS W1C: write 1 clears bit; hardware set in same cycle as clear -> set wins.
- irq_o = |IRQ_STATUS (combinational from flops, no mask beyond enables).
- Reads: reg_re at edge k -> reg_rdata valid after edge k, held until next reg_re. Read without side effects. Simultaneous reg_re and reg_we same address: rdata returns pre-write value.

## Timing
- Reset: all registers, sync flops, cnt, f cleared to 0; pad_out_o=0, pad_oe_o=0, reg_rdata=0, irq_o=0. Reset mid-filter or with pending status discards everything at next edge.
- Write latency: DATA_OUT/OUT_EN/OUT_SET/OUT_CLR written at edge k -> pad pins change after edge k (1 cycle).
- Input latency, filter off: pad_in_i stable before edge k -> s valid after edge k+SYNC_STAGES-1 -> f/DATA_IN and IRQ_STATUS after edge k+SYNC_STAGES -> irq_o same cycle.
- Filter on: add FILT_TH cycles to the above.
- Pad high at reset release with FILT_EN=0: f rises SYNC_STAGES+1 edges after release; no status since enables are 0.

## Test plan
- Reset: hold rst 3 cycles with pad_in_i=all 1 -> all outputs 0; read DATA_IN after 4 cycles post-release -> 0xFFFFFFFF, IRQ_STATUS=0.
- Outputs: write DATA_OUT=0x0000_00F0, OUT_EN=0xFF, OUT_SET=0x0F, OUT_CLR=0x30 -> pad_out_o=0xCF, pad_oe_o=0xFF, each one cycle after its write; read OUT_SET -> 0.
- Filter: FILT_EN[0]=1, FILT_TH=3; pulse pad_in_i[0] high 3 cycles -> DATA_IN[0] stays 0; hold high 4 cycles -> DATA_IN[0]=1 exactly 2+4 edges after rise.
- IRQ: IRQ_RISE_EN[5]=1, FALL_EN[5]=0; toggle pin 5 0->1->0 -> IRQ_STATUS=0x20, irq_o=1 after edge k+2; W1C 0x20 -> irq_o=0 next cycle.
- Collision: W1C bit 5 on the same edge a new rising edge on pin 5 is filtered -> IRQ_STATUS[5] stays 1.
- Params NUM_CH=8: write 0xFFFFFFFF to DATA_OUT, read back -> 0x000000FF; reads of addresses 10..15 -> 0.

Source files
------------

// File: rtl/gpio_padctrl.sv
// GPIO pad controller: register-mapped pad outputs, synchronised and glitch-filtered
// inputs, and sticky edge-triggered interrupt status.
module gpio_padctrl #(
  parameter int unsigned NUM_CH      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_we,
  input  logic              reg_re,
  input  logic [3:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  input  logic [NUM_CH-1:0] pad_in_i,
  output logic [NUM_CH-1:0] pad_out_o,
  output logic [NUM_CH-1:0] pad_oe_o,
  output logic              irq_o
);

  localparam logic [3:0] ADDR_DATA_OUT    = 4'd0;
  localparam logic [3:0] ADDR_OUT_EN      = 4'd1;
  localparam logic [3:0] ADDR_DATA_IN     = 4'd2;
  localparam logic [3:0] ADDR_FILT_EN     = 4'd3;
  localparam logic [3:0] ADDR_FILT_TH     = 4'd4;
  localparam logic [3:0] ADDR_IRQ_RISE_EN = 4'd5;
  localparam logic [3:0] ADDR_IRQ_FALL_EN = 4'd6;
  localparam logic [3:0] ADDR_IRQ_STATUS  = 4'd7;
  localparam logic [3:0] ADDR_OUT_SET     = 4'd8;
  localparam logic [3:0] ADDR_OUT_CLR     = 4'd9;

  logic [NUM_CH-1:0] data_out_q, data_out_d;
  logic [NUM_CH-1:0] out_en_q, out_en_d;
  logic [NUM_CH-1:0] filt_en_q, filt_en_d;
  logic [FILT_W-1:0] filt_th_q, filt_th_d;
  logic [NUM_CH-1:0] rise_en_q, rise_en_d;
  logic [NUM_CH-1:0] fall_en_q, fall_en_d;
  logic [NUM_CH-1:0] irq_status_q, irq_status_d;
  logic [NUM_CH-1:0] filt_q, filt_d;
  logic [FILT_W-1:0] cnt_q [NUM_CH];
  logic [FILT_W-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
  logic [31:0]       rdata_q, rdata_d;

  logic [NUM_CH-1:0] wdata_ch;
  logic [NUM_CH-1:0] sync_out;
  logic [NUM_CH-1:0] w1c;
  logic [NUM_CH-1:0] irq_set;
  logic [31:0]       rd_val;

  assign wdata_ch = reg_wdata[NUM_CH-1:0];
  assign sync_out = sync_q[SYNC_STAGES-1];

  // Input synchroniser shift chain
  always_comb begin
    for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i];
    sync_d[0] = pad_in_i;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // Glitch filter: a mismatch must outlast the threshold before f follows s
  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (!filt_en_q[i]) begin
        filt_d[i] = sync_out[i];
      end else if (sync_out[i] != filt_q[i]) begin
        if (cnt_q[i] >= filt_th_q) filt_d[i] = sync_out[i];
        else                       cnt_d[i] = cnt_q[i] + FILT_W'(1);
      end
    end
  end

  assign irq_set = (filt_d & ~filt_q & rise_en_q) | (~filt_d & filt_q & fall_en_q);

  // Register writes; hardware status set takes priority over W1C
  always_comb begin
    data_out_d = data_out_q;
    out_en_d   = out_en_q;
    filt_en_d  = filt_en_q;
    filt_th_d  = filt_th_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    w1c        = '0;
    if (reg_we) begin
      case (reg_addr)
        ADDR_DATA_OUT:    data_out_d = wdata_ch;
        ADDR_OUT_EN:      out_en_d   = wdata_ch;
        ADDR_FILT_EN:     filt_en_d  = wdata_ch;
        ADDR_FILT_TH:     filt_th_d  = reg_wdata[FILT_W-1:0];
        ADDR_IRQ_RISE_EN: rise_en_d  = wdata_ch;
        ADDR_IRQ_FALL_EN: fall_en_d  = wdata_ch;
        ADDR_IRQ_STATUS:  w1c        = wdata_ch;
        ADDR_OUT_SET:     data_out_d = data_out_q | wdata_ch;
        ADDR_OUT_CLR:     data_out_d = data_out_q & ~wdata_ch;
        default: ;
      endcase
    end
    irq_status_d = (irq_status_q & ~w1c) | irq_set;
  end

  // Read mux samples pre-write register state
  always_comb begin
    rd_val = '0;
    case (reg_addr)
      ADDR_DATA_OUT:    rd_val = 32'(data_out_q);
      ADDR_OUT_EN:      rd_val = 32'(out_en_q);
      ADDR_DATA_IN:     rd_val = 32'(filt_q);
      ADDR_FILT_EN:     rd_val = 32'(filt_en_q);
      ADDR_FILT_TH:     rd_val = 32'(filt_th_q);
      ADDR_IRQ_RISE_EN: rd_val = 32'(rise_en_q);
      ADDR_IRQ_FALL_EN: rd_val = 32'(fall_en_q);
      ADDR_IRQ_STATUS:  rd_val = 32'(irq_status_q);
      default:          rd_val = '0;
    endcase
    rdata_d = reg_re ? rd_val : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q   <= '0;
      out_en_q     <= '0;
      filt_en_q    <= '0;
      filt_th_q    <= '0;
      rise_en_q    <= '0;
      fall_en_q    <= '0;
      irq_status_q <= '0;
      filt_q       <= '0;
      rdata_q      <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++)      cnt_q[i]  <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      data_out_q   <= data_out_d;
      out_en_q     <= out_en_d;
      filt_en_q    <= filt_en_d;
      filt_th_q    <= filt_th_d;
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      irq_status_q <= irq_status_d;
      filt_q       <= filt_d;
      rdata_q      <= rdata_d;
      for (int unsigned i = 0; i < NUM_CH; i++)      cnt_q[i]  <= cnt_d[i];
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign reg_rdata = rdata_q;
  assign pad_out_o = data_out_q;
  assign pad_oe_o  = out_en_q;
  assign irq_o     = |irq_status_q;

endmodule

// File: tb/tb_gpio_padctrl.sv
// Scoreboard bench for gpio_padctrl: a 32-channel instance plus an 8-channel
// instance sharing the register bus; expectations queued by stimulus, checked by monitor.
module tb_gpio_padctrl;

  localparam int K_READ  = 0;  // registered read data, checked when read returns
  localparam int K_OUT   = 1;
  localparam int K_OE    = 2;
  localparam int K_IRQ   = 3;
  localparam int K_RDATA = 4;  // reg_rdata sampled directly
  localparam int K_OUT8  = 5;  // {irq, oe, out} of the 8-channel instance

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
    logic [31:0] exp8;
    bit          chk8;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_we, reg_re;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata, reg_rdata8;
  logic [31:0] pad_in;
  logic [31:0] pad_out, pad_oe;
  logic [7:0]  pad_out8, pad_oe8;
  logic        irq, irq8;
  logic        rd_vld = 1'b0;

  sb_item_t sb_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  gpio_padctrl #(.NUM_CH(32), .SYNC_STAGES(2), .FILT_W(4)) u_dut (
    .clk(clk), .rst(rst), .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .pad_in_i(pad_in),
    .pad_out_o(pad_out), .pad_oe_o(pad_oe), .irq_o(irq)
  );

  gpio_padctrl #(.NUM_CH(8), .SYNC_STAGES(2), .FILT_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata8), .pad_in_i(pad_in[7:0]),
    .pad_out_o(pad_out8), .pad_oe_o(pad_oe8), .irq_o(irq8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_vld <= reg_re;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pin checks drain immediately, one read item per returned read
  always @(negedge clk) begin
    bit used;
    sb_item_t it;
    logic [31:0] act;
    used = 1'b0;
    while (sb_q.size() != 0) begin
      if (sb_q[0].kind == K_READ) begin
        if (!rd_vld || used) break;
        used = 1'b1;
      end
      it = sb_q.pop_front();
      case (it.kind)
        K_OUT:   act = pad_out;
        K_OE:    act = pad_oe;
        K_IRQ:   act = {31'b0, irq};
        K_OUT8:  act = {15'b0, irq8, pad_oe8, pad_out8};
        default: act = reg_rdata;
      endcase
      check(it.name, act, it.exp);
      if (it.chk8) check({it.name, "_ch8"}, reg_rdata8, it.exp8);
    end
  end

  task automatic push(input string name, input int kind, input logic [31:0] exp,
                      input logic [31:0] exp8 = '0, input bit chk8 = 1'b0);
    sb_item_t it;
    it.name = name; it.kind = kind; it.exp = exp; it.exp8 = exp8; it.chk8 = chk8;
    sb_q.push_back(it);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name,
                    input logic [31:0] exp8 = '0, input bit chk8 = 1'b0);
    push(name, K_READ, exp, exp8, chk8);
    reg_re = 1'b1; reg_addr = a;
    tick();
    reg_re = 1'b0;
  endtask

  task automatic rdwr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp,
                      input string name);
    push(name, K_READ, exp);
    reg_re = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_re = 1'b0; reg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; reg_we = 1'b0; reg_re = 1'b0; reg_addr = '0; reg_wdata = '0;
    pad_in = '1;

    // Reset with pads high
    tick(3);
    push("rst_out", K_OUT, 32'h0);
    push("rst_oe", K_OE, 32'h0);
    push("rst_irq", K_IRQ, 32'h0);
    push("rst_rdata", K_RDATA, 32'h0);
    push("rst_ch8", K_OUT8, 32'h0);
    rst = 1'b0;
    tick(4);
    rd(4'd2, 32'hFFFF_FFFF, "datain_after_rst");
    rd(4'd7, 32'h0, "status_after_rst");
    pad_in = '0;
    tick(5);
    rd(4'd2, 32'h0, "datain_low");

    // Output registers
    wr(4'd0, 32'h0000_00F0);
    push("out_write", K_OUT, 32'h0000_00F0);
    wr(4'd1, 32'h0000_00FF);
    push("oe_write", K_OE, 32'h0000_00FF);
    wr(4'd8, 32'h0000_000F);
    push("out_set", K_OUT, 32'h0000_00FF);
    wr(4'd9, 32'h0000_0030);
    push("out_clr", K_OUT, 32'h0000_00CF);
    rd(4'd8, 32'h0, "read_out_set");
    rd(4'd9, 32'h0, "read_out_clr");
    rd(4'd0, 32'h0000_00CF, "read_data_out");
    rdwr(4'd0, 32'h0000_0012, 32'h0000_00CF, "rdwr_prewrite");
    push("rdwr_out", K_OUT, 32'h0000_0012);

    // Glitch filter on channel 0, threshold 3
    wr(4'd3, 32'h1);
    wr(4'd4, 32'hFFFF_FFF3);
    rd(4'd4, 32'h3, "filt_th_read");
    pad_in[0] = 1'b1;
    tick(3);
    pad_in[0] = 1'b0;
    tick(6);
    rd(4'd2, 32'h0, "filt_short_pulse");
    pad_in[0] = 1'b1;
    tick(5);
    rd(4'd2, 32'h0, "filt_before_accept");
    rd(4'd2, 32'h1, "filt_accept");
    wr(4'd3, 32'h0);

    // Rising-edge interrupt on channel 5
    wr(4'd5, 32'h20);
    wr(4'd6, 32'h0);
    pad_in[5] = 1'b1;
    tick(2);
    push("irq_before", K_IRQ, 32'h0);
    tick();
    push("irq_rise", K_IRQ, 32'h1);
    pad_in[5] = 1'b0;
    tick(4);
    rd(4'd7, 32'h20, "status_rise_only");
    wr(4'd7, 32'h20);
    push("irq_w1c", K_IRQ, 32'h0);
    rd(4'd7, 32'h0, "status_cleared");

    // W1C collides with a new hardware set
    pad_in[5] = 1'b1;
    tick(2);
    wr(4'd7, 32'h20);
    push("irq_collision", K_IRQ, 32'h1);
    rd(4'd7, 32'h20, "status_collision");
    wr(4'd7, 32'h20);
    push("irq_clear2", K_IRQ, 32'h0);

    // Falling-edge interrupt on channel 6
    wr(4'd6, 32'h40);
    pad_in[6] = 1'b1;
    tick(4);
    rd(4'd7, 32'h0, "status_no_fall_on_rise");
    pad_in[6] = 1'b0;
    tick(4);
    rd(4'd7, 32'h40, "status_fall");

    // Channel-count masking and reserved addresses
    wr(4'd0, 32'hFFFF_FFFF);
    rd(4'd0, 32'hFFFF_FFFF, "data_out_wide", 32'h0000_00FF, 1'b1);
    push("ch8_pins", K_OUT8, 32'h0001_FFFF);
    wr(4'd10, 32'hFFFF_FFFF);
    for (int a = 10; a < 16; a++) rd(4'(a), 32'h0, $sformatf("reserved_%0d", a), 32'h0, 1'b1);

    // Reset discards pending state
    rst = 1'b1;
    tick();
    push("rst2_out", K_OUT, 32'h0);
    push("rst2_irq", K_IRQ, 32'h0);
    push("rst2_ch8", K_OUT8, 32'h0);
    rst = 1'b0;
    rd(4'd7, 32'h0, "rst2_status");

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
